// File: rtl/mux4.sv
// Parameterised 4:1 data multiplexer: a zero-latency combinational output
// plus a registered copy of the selected data, its select, and a sticky valid flag.
module mux4 #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_c,
  input  logic [WIDTH-1:0] i_d,
  input  logic [1:0]       i_sel,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_out,
  output logic [WIDTH-1:0] o_out_q,
  output logic [1:0]       o_sel_q,
  output logic             o_valid_q
);

  // The registered path captures the same mux result that drives o_out.
  // A shared decode keeps the two paths from ever disagreeing.
  always_comb begin
    // NOTE: assign a default before the case so no path can leave o_out unassigned and infer a latch.
    o_out = '0;
    case (i_sel)
      2'd0:    o_out = i_a;
      2'd1:    o_out = i_b;
      2'd2:    o_out = i_c;
      2'd3:    o_out = i_d;
      default: o_out = '0;
    endcase
  end

  // o_valid_q is sticky: once any capture happens it stays high until reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!i_rst_n) begin
      o_out_q   <= '0;
      o_sel_q   <= 2'd0;
      o_valid_q <= 1'b0;
    end else if (i_en) begin
      o_out_q   <= o_out;
      o_sel_q   <= i_sel;
      o_valid_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mux4.sv
// Directed self-checking bench for mux4: one WIDTH=8 instance and one WIDTH=1
// instance sharing clock and reset.
module tb_mux4;

  logic       clk;
  logic       rst_n;
  logic       clk_run;

  logic [7:0] a, b, c, d;
  logic [1:0] sel;
  logic       en;
  logic [7:0] out, out_q;
  logic [1:0] sel_q;
  logic       valid_q;

  logic       a1, b1, c1, d1;
  logic [1:0] sel1;
  logic       en1;
  logic       out1, out_q1;
  logic [1:0] sel_q1;
  logic       valid_q1;

  int checks = 0;
  int errors = 0;

  mux4 #(.WIDTH(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_a(a), .i_b(b), .i_c(c), .i_d(d),
    .i_sel(sel), .i_en(en),
    .o_out(out), .o_out_q(out_q), .o_sel_q(sel_q), .o_valid_q(valid_q)
  );

  mux4 #(.WIDTH(1)) dut_w1 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_a(a1), .i_b(b1), .i_c(c1), .i_d(d1),
    .i_sel(sel1), .i_en(en1),
    .o_out(out1), .o_out_q(out_q1), .o_sel_q(sel_q1), .o_valid_q(valid_q1)
  );

  // Clock only toggles once clk_run is set, so the combinational test sees no edges.
  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1);
  end

  task automatic test_reset();
    #2;
    checks++;
    if (out_q !== 8'h00) begin errors++; $display("FAIL reset_out_q: got %h, expected 00", out_q); end
    checks++;
    if (sel_q !== 2'd0) begin errors++; $display("FAIL reset_sel_q: got %0d, expected 0", sel_q); end
    checks++;
    if (valid_q !== 1'b0) begin errors++; $display("FAIL reset_valid_q: got %b, expected 0", valid_q); end
    checks++;
    if (valid_q1 !== 1'b0) begin errors++; $display("FAIL reset_valid_q_w1: got %b, expected 0", valid_q1); end
  endtask

  task automatic test_comb_select();
    logic [7:0] exp_tab [4];
    exp_tab = '{8'd1, 8'd2, 8'd3, 8'd4};
    a = 8'd1; b = 8'd2; c = 8'd3; d = 8'd4;
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i);
      #1;
      checks++;
      if (out !== exp_tab[i]) begin
        errors++; $display("FAIL comb_sel%0d: got %h, expected %h", i, out, exp_tab[i]);
      end
    end
  endtask

  task automatic test_capture();
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b1; sel = 2'd2; c = 8'hA7;
    #1;
    checks++;
    if (valid_q !== 1'b0) begin errors++; $display("FAIL capture_pre_valid: got %b, expected 0", valid_q); end
    @(posedge clk); #1;
    checks++;
    if (out_q !== 8'hA7) begin errors++; $display("FAIL capture_out_q: got %h, expected a7", out_q); end
    checks++;
    if (sel_q !== 2'd2) begin errors++; $display("FAIL capture_sel_q: got %0d, expected 2", sel_q); end
    checks++;
    if (valid_q !== 1'b1) begin errors++; $display("FAIL capture_valid_q: got %b, expected 1", valid_q); end
  endtask

  task automatic test_enable_hold();
    @(negedge clk);
    en = 1'b0; sel = 2'd3; d = 8'h3C;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_q !== 8'hA7) begin errors++; $display("FAIL hold_out_q%0d: got %h, expected a7", i, out_q); end
      checks++;
      if (sel_q !== 2'd2) begin errors++; $display("FAIL hold_sel_q%0d: got %0d, expected 2", i, sel_q); end
      checks++;
      if (valid_q !== 1'b1) begin errors++; $display("FAIL hold_valid_q%0d: got %b, expected 1", i, valid_q); end
    end
    checks++;
    if (out !== 8'h3C) begin errors++; $display("FAIL hold_out: got %h, expected 3c", out); end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    en = 1'b1; sel = 2'd0; a = 8'h55;
    @(posedge clk); #1;
    checks++;
    if (out_q !== 8'h55) begin errors++; $display("FAIL arst_pre_out_q: got %h, expected 55", out_q); end
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_q !== 8'h00) begin errors++; $display("FAIL arst_out_q: got %h, expected 00", out_q); end
    checks++;
    if (sel_q !== 2'd0) begin errors++; $display("FAIL arst_sel_q: got %0d, expected 0", sel_q); end
    checks++;
    if (valid_q !== 1'b0) begin errors++; $display("FAIL arst_valid_q: got %b, expected 0", valid_q); end
    sel = 2'd1; b = 8'h99;
    #1;
    checks++;
    if (out !== 8'h99) begin errors++; $display("FAIL arst_out_tracks: got %h, expected 99", out); end
    // An edge while reset is still low must not capture even with en high.
    @(posedge clk); #1;
    checks++;
    if (out_q !== 8'h00) begin errors++; $display("FAIL arst_edge_out_q: got %h, expected 00", out_q); end
    checks++;
    if (valid_q !== 1'b0) begin errors++; $display("FAIL arst_edge_valid_q: got %b, expected 0", valid_q); end
    @(negedge clk);
    rst_n = 1'b1; en = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (valid_q !== 1'b0) begin errors++; $display("FAIL arst_release_valid_q: got %b, expected 0", valid_q); end
  endtask

  task automatic b2b_step(input logic [1:0] s, input logic [7:0] exp_data, input int idx);
    @(negedge clk);
    en = 1'b1; sel = s;
    @(posedge clk); #1;
    checks++;
    if (out_q !== exp_data) begin errors++; $display("FAIL b2b_out_q%0d: got %h, expected %h", idx, out_q, exp_data); end
    checks++;
    if (sel_q !== s) begin errors++; $display("FAIL b2b_sel_q%0d: got %0d, expected %0d", idx, sel_q, s); end
  endtask

  task automatic test_back_to_back();
    a = 8'h0F; b = 8'h11; c = 8'hC3; d = 8'hF0;
    b2b_step(2'd1, 8'h11, 0);
    b2b_step(2'd3, 8'hF0, 1);
    b2b_step(2'd0, 8'h0F, 2);
    b2b_step(2'd2, 8'hC3, 3);
    c = 8'h5A;
    b2b_step(2'd2, 8'h5A, 4);
    checks++;
    if (valid_q !== 1'b1) begin errors++; $display("FAIL b2b_valid_q: got %b, expected 1", valid_q); end
  endtask

  task automatic test_width1();
    logic exp_tab [4];
    exp_tab = '{1'b1, 1'b0, 1'b1, 1'b0};
    a1 = 1'b1; b1 = 1'b0; c1 = 1'b1; d1 = 1'b0; en1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      sel1 = 2'(i);
      #1;
      checks++;
      if (out1 !== exp_tab[i]) begin errors++; $display("FAIL w1_out%0d: got %b, expected %b", i, out1, exp_tab[i]); end
      @(posedge clk); #1;
      checks++;
      if (out_q1 !== exp_tab[i]) begin errors++; $display("FAIL w1_out_q%0d: got %b, expected %b", i, out_q1, exp_tab[i]); end
      checks++;
      if (sel_q1 !== 2'(i)) begin errors++; $display("FAIL w1_sel_q%0d: got %0d, expected %0d", i, sel_q1, i); end
    end
    checks++;
    if (valid_q1 !== 1'b1) begin errors++; $display("FAIL w1_valid_q: got %b, expected 1", valid_q1); end
  endtask

  initial begin
    clk = 1'b0; clk_run = 1'b0; rst_n = 1'b0;
    a = '0; b = '0; c = '0; d = '0; sel = 2'd0; en = 1'b0;
    a1 = 1'b0; b1 = 1'b0; c1 = 1'b0; d1 = 1'b0; sel1 = 2'd0; en1 = 1'b0;

    test_reset();
    test_comb_select();
    clk_run = 1'b1;
    test_capture();
    test_enable_hold();
    test_async_reset();
    test_back_to_back();
    test_width1();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux4.md
Name:
mux4

Overview:
- Parameterised 4:1 data multiplexer with a zero-latency combinational output and a registered copy of the selected data.
- Used wherever one of four equal-width data sources is steered onto a single bus.
- The combinational path serves same-cycle consumers; the registered path serves timing-critical downstream logic.

Parameters:
- WIDTH, 8, bit width of every data input and of both data outputs (legal: WIDTH >= 1).

Ports:
- i_clk  input  1  clock; all registers update on its rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_a  input  WIDTH  data source 0.
- i_b  input  WIDTH  data source 1.
- i_c  input  WIDTH  data source 2.
- i_d  input  WIDTH  data source 3.
- i_sel  input  2  source select.
- i_en  input  1  capture enable for the registered path.
- o_out  output  WIDTH  combinational selected data.
- o_out_q  output  WIDTH  registered selected data.
- o_sel_q  output  2  select value captured with o_out_q.
- o_valid_q  output  1  high once o_out_q holds captured data since the last reset.

Behaviour:
- Interface: one clock (i_clk); reset i_rst_n is asynchronous and active-low.
- Select decode, applied to o_out:
  - i_sel=0 -> i_a
  - i_sel=1 -> i_b
  - i_sel=2 -> i_c
  - i_sel=3 -> i_d
- o_out timing:
  - purely combinational, zero latency;
  - independent of i_clk, i_rst_n and i_en;
  - settles within the same time step after any input change.
- i_sel containing X/Z: o_out is don't-care in simulation. The synthesised default branch drives all-zero.
- Reset (i_rst_n low): immediately, without waiting for a clock edge, o_out_q=0, o_sel_q=0 and o_valid_q=0. These values hold while reset is low.
- Reset deassertion: takes effect at the next rising edge of i_clk. No data is captured on the edge at which reset is still low.
- Rising edge of i_clk with i_en=1: o_out_q <= mux result for current i_sel; o_sel_q <= i_sel; o_valid_q <= 1. Latency from inputs to o_out_q is exactly one clock.
- Rising edge with i_en=0: o_out_q, o_sel_q and o_valid_q hold their values.
- o_valid_q stays high until the next reset. It is sticky, not a per-capture pulse.
- Reset asserted mid-operation: registered outputs clear asynchronously. o_out continues to follow the inputs.
- Simultaneous change of i_sel and data just before an edge: the values present at the edge are captured. There is no extra pipelining.
- No internal state other than the three registers. No handshake beyond i_en.

Test Plan:
- Combinational select: WIDTH=8, i_a=1, i_b=2, i_c=3, i_d=4, no clock toggling; step i_sel 0,1,2,3 with 1 ns between steps -> o_out = 1, 2, 3, 4 respectively, each compared with exact (!==) equality.
- Async reset: clocks running, o_out_q=0x55; drive i_rst_n low between edges -> o_out_q=0, o_sel_q=0, o_valid_q=0 before the next edge, while o_out still tracks i_sel.
- Registered capture: reset released, i_en=1, i_sel=2, i_c=0xA7, one rising edge -> o_out_q=0xA7, o_sel_q=2, o_valid_q=1.
- Enable hold: after the capture above, set i_en=0, change i_sel to 3 and i_d to 0x3C, apply 3 edges -> o_out_q stays 0xA7 and o_sel_q stays 2, while o_out=0x3C.
- Width corner: WIDTH=1, i_a=1, i_b=0, i_c=1, i_d=0, sweep i_sel 0..3 -> o_out = 1, 0, 1, 0; with i_en=1, o_out_q matches o_out one edge later.
